video_frame_packetizer: RTL and testbench

//  Source end of the Avalon-ST video path. Turns a free-running camera pixel bus
//  (valid + frame_start strobe, cannot stall) into SOP/EOP-framed packets of

---
 rtl/video_st_pkg.sv | 25 ++
 rtl/video_beat_fifo.sv | 76 +++++++
 rtl/video_frame_packetizer.sv | 186 ++++++++++++++++++
 tb/tb_video_frame_packetizer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_st_pkg.sv
// Shared types for the Avalon-ST video source path: beat control flags and
// packetizer state encoding.
package video_st_pkg;

  localparam int DATA_W_DEF = 24;

  typedef struct packed {
    logic sop;
    logic eop;
  } beat_ctl_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    CLOSE      = 2'd2
  } state_e;

  function automatic beat_ctl_t make_ctl(input logic sop, input logic eop);
    beat_ctl_t c;
    c.sop = sop;
    c.eop = eop;
    return c;
  endfunction

endpackage

// File: rtl/video_beat_fifo.sv
// Synchronous show-ahead FIFO for {sop,eop,data} beats with a synchronous
// flush; a push into a full FIFO is honoured when a pop happens the same cycle.
module video_beat_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == CW'(0));
  assign pop_data = mem_q[rd_q];

  // Next-state pointers, occupancy and storage.
  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    if (clear) begin
      wr_d    = AW'(0);
      rd_d    = AW'(0);
      count_d = CW'(0);
    end else begin
      if (push_ok_s) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= AW'(0);
      rd_q    <= AW'(0);
      count_q <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= W'(0);
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/video_frame_packetizer.sv
// Converts a non-stallable camera pixel bus into SOP/EOP-framed Avalon-ST
// packets of WIDTH*HEIGHT beats, closing broken frames with a filler EOP beat.
module video_frame_packetizer
  import video_st_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_valid,
  input  logic [DATA_W-1:0] pixel_data,
  input  logic              pixel_frame_start,
  input  logic              video_stream_reset,
  input  logic              stream_ready,
  output logic              stream_valid,
  output logic [DATA_W-1:0] stream_data,
  output logic              stream_startofpacket,
  output logic              stream_endofpacket,
  output logic              overflow_err,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BW = DATA_W + 2;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_next_s;
  logic [YW-1:0] y_q, y_d, y_next_s;
  logic          ovf_q, ovf_d, ferr_q, ferr_d;
  logic [15:0]   fc_q, fc_d;

  logic          push_s, pop_s, room_s, last_s, accept_s;
  logic          full_s, empty_s;
  beat_ctl_t     push_ctl_s, head_ctl_s;
  logic [DATA_W-1:0] push_data_s, head_data_s;
  logic [BW-1:0] head_word_s;

  video_beat_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (!video_stream_reset),
    .push      (push_s),
    .push_data ({push_ctl_s, push_data_s}),
    .pop       (pop_s),
    .pop_data  (head_word_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign head_ctl_s  = head_word_s[BW-1 -: 2];
  assign head_data_s = head_word_s[DATA_W-1:0];

  assign stream_valid         = !empty_s;
  assign stream_data          = stream_valid ? head_data_s : DATA_W'(0);
  assign stream_startofpacket = stream_valid & head_ctl_s.sop;
  assign stream_endofpacket   = stream_valid & head_ctl_s.eop;
  assign overflow_err         = ovf_q;
  assign frame_err            = ferr_q;
  assign frame_count          = fc_q;

  assign pop_s  = stream_valid && stream_ready;
  assign room_s = !full_s || pop_s;
  assign last_s = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));

  // Raster position following the current pixel.
  always_comb begin
    x_next_s = x_q + XW'(1);
    y_next_s = y_q;
    if (x_q == XW'(WIDTH - 1)) begin
      x_next_s = XW'(0);
      y_next_s = (y_q == YW'(HEIGHT - 1)) ? YW'(0) : (y_q + YW'(1));
    end else begin
      y_next_s = y_q;
    end
  end

  // FSM next state, FIFO push request and error/frame bookkeeping.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    ferr_d      = ferr_q;
    fc_d        = fc_q;
    push_s      = 1'b0;
    push_ctl_s  = make_ctl(1'b0, 1'b0);
    push_data_s = DATA_W'(0);
    accept_s    = 1'b0;
    if (!video_stream_reset) begin
      state_d = WAIT_FRAME;
      x_d     = XW'(0);
      y_d     = YW'(0);
    end else begin
      case (state_q)
        WAIT_FRAME: begin
          // No packet is open yet, so a dropped first pixel needs no filler.
          if (pixel_valid && pixel_frame_start) begin
            if (room_s) begin
              accept_s = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            state_d = WAIT_FRAME;
          end
        end
        ACTIVE: begin
          if (pixel_valid) begin
            if (pixel_frame_start) begin
              ferr_d  = 1'b1;
              state_d = CLOSE;
              x_d     = XW'(0);
              y_d     = YW'(0);
            end else if (!room_s) begin
              ovf_d   = 1'b1;
              state_d = CLOSE;
              x_d     = XW'(0);
              y_d     = YW'(0);
            end else begin
              accept_s = 1'b1;
            end
          end else begin
            state_d = ACTIVE;
          end
        end
        CLOSE: begin
          if (!full_s) begin
            push_s     = 1'b1;
            push_ctl_s = make_ctl(1'b0, 1'b1);
            state_d    = WAIT_FRAME;
          end else begin
            state_d = CLOSE;
          end
        end
        default: begin
          state_d = WAIT_FRAME;
          x_d     = XW'(0);
          y_d     = YW'(0);
        end
      endcase
      if (accept_s) begin
        push_s      = 1'b1;
        push_ctl_s  = make_ctl(state_q == WAIT_FRAME, last_s);
        push_data_s = pixel_data;
        x_d         = x_next_s;
        y_d         = y_next_s;
        if (last_s) begin
          state_d = WAIT_FRAME;
          fc_d    = fc_q + 16'd1;
        end else begin
          state_d = ACTIVE;
        end
      end else begin
        push_data_s = DATA_W'(0);
      end
    end
  end

  // Packetizer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_FRAME;
      x_q     <= XW'(0);
      y_q     <= YW'(0);
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      fc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      fc_q    <= fc_d;
    end
  end

endmodule

// File: tb/tb_video_frame_packetizer.sv
// Directed bench for video_frame_packetizer with WIDTH=4, HEIGHT=2, FIFO_DEPTH=4.
module tb_video_frame_packetizer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset, pixel_valid, pixel_frame_start, video_stream_reset, stream_ready;
  logic [DW-1:0] pixel_data;
  logic          stream_valid, stream_startofpacket, stream_endofpacket;
  logic [DW-1:0] stream_data;
  logic          overflow_err, frame_err;
  logic [15:0]   frame_count;

  int tests = 0;
  int fails = 0;
  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];

  always #5 clk = ~clk;

  video_frame_packetizer #(
    .DATA_W(DW), .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .pixel_valid          (pixel_valid),
    .pixel_data           (pixel_data),
    .pixel_frame_start    (pixel_frame_start),
    .video_stream_reset   (video_stream_reset),
    .stream_ready         (stream_ready),
    .stream_valid         (stream_valid),
    .stream_data          (stream_data),
    .stream_startofpacket (stream_startofpacket),
    .stream_endofpacket   (stream_endofpacket),
    .overflow_err         (overflow_err),
    .frame_err            (frame_err),
    .frame_count          (frame_count)
  );

  always @(negedge clk)
    if (stream_valid === 1'b1 && stream_ready === 1'b1)
      got_q.push_back({stream_startofpacket, stream_endofpacket, stream_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [DW-1:0] d, input logic fs);
    pixel_valid       = 1'b1;
    pixel_data        = d;
    pixel_frame_start = fs;
    tick();
    pixel_valid       = 1'b0;
    pixel_frame_start = 1'b0;
    pixel_data        = '0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int i = 1; i <= 8; i++) pix(base + DW'(i), i == 1);
  endtask

  task automatic exp_frame(input logic [DW-1:0] base);
    for (int i = 1; i <= 8; i++) exp_q.push_back({i == 1, i == 8, base + DW'(i)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && stream_valid; i++) tick();
    chk("drain_timeout", {31'd0, stream_valid}, 32'd0);
  endtask

  task automatic check_beats(input string name);
    logic [25:0] obs;
    chk($sformatf("%s_count", name), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 'x;
      chk($sformatf("%s_beat%0d", name, i), {6'd0, obs}, {6'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // One test-6 cycle: toggle ready and confirm a stalled beat holds steady.
  task automatic t6_step(input logic v, input logic [DW-1:0] d, input logic fs);
    logic        stall;
    logic [26:0] snap;
    pixel_valid       = v;
    pixel_data        = d;
    pixel_frame_start = fs;
    stream_ready      = !stream_ready;
    stall = stream_valid && !stream_ready;
    snap  = {stream_valid, stream_startofpacket, stream_endofpacket, stream_data};
    tick();
    if (stall)
      chk("t6_stable", {5'd0, stream_valid, stream_startofpacket, stream_endofpacket, stream_data},
          {5'd0, snap});
    pixel_valid       = 1'b0;
    pixel_frame_start = 1'b0;
    pixel_data        = '0;
  endtask

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; pixel_data = '0; pixel_frame_start = 1'b0;
    video_stream_reset = 1'b1; stream_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, stream_valid}, 32'd0);
    chk("rst_sop", {31'd0, stream_startofpacket}, 32'd0);
    chk("rst_eop", {31'd0, stream_endofpacket}, 32'd0);
    chk("rst_data", {8'd0, stream_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_fc", {16'd0, frame_count}, 32'd0);
    reset = 1'b0;

    // 1: clean frame, sink always ready
    do_reset();
    stream_ready = 1'b1;
    send_frame(24'd0);
    exp_frame(24'd0);
    drain();
    check_beats("t1");
    chk("t1_fc", {16'd0, frame_count}, 32'd1);
    chk("t1_ovf", {31'd0, overflow_err}, 32'd0);
    chk("t1_ferr", {31'd0, frame_err}, 32'd0);

    // 2: stray pixels before the first frame_start are discarded
    do_reset();
    stream_ready = 1'b1;
    pix(24'd9, 1'b0);
    pix(24'd10, 1'b0);
    send_frame(24'd0);
    exp_frame(24'd0);
    drain();
    check_beats("t2");
    chk("t2_fc", {16'd0, frame_count}, 32'd1);

    // 3: overflow under full backpressure, closed by filler beat
    do_reset();
    stream_ready = 1'b0;
    send_frame(24'd0);
    chk("t3_ovf", {31'd0, overflow_err}, 32'd1);
    chk("t3_valid_held", {31'd0, stream_valid}, 32'd1);
    chk("t3_no_pop", got_q.size(), 32'd0);
    stream_ready = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 24'd1});
    exp_q.push_back({1'b0, 1'b0, 24'd2});
    exp_q.push_back({1'b0, 1'b0, 24'd3});
    exp_q.push_back({1'b0, 1'b0, 24'd4});
    exp_q.push_back({1'b0, 1'b1, 24'd0});
    drain();
    check_beats("t3");
    chk("t3_fc", {16'd0, frame_count}, 32'd0);
    chk("t3_ferr", {31'd0, frame_err}, 32'd0);

    // 4: frame_start mid-frame, then an intact frame
    do_reset();
    stream_ready = 1'b1;
    for (int i = 1; i <= 4; i++) pix(DW'(i), i == 1);
    pix(24'd5, 1'b1);
    for (int i = 6; i <= 8; i++) pix(DW'(i), 1'b0);
    send_frame(24'h100);
    exp_q.push_back({1'b1, 1'b0, 24'd1});
    exp_q.push_back({1'b0, 1'b0, 24'd2});
    exp_q.push_back({1'b0, 1'b0, 24'd3});
    exp_q.push_back({1'b0, 1'b0, 24'd4});
    exp_q.push_back({1'b0, 1'b1, 24'd0});
    exp_frame(24'h100);
    drain();
    check_beats("t4");
    chk("t4_ferr", {31'd0, frame_err}, 32'd1);
    chk("t4_ovf", {31'd0, overflow_err}, 32'd0);
    chk("t4_fc", {16'd0, frame_count}, 32'd1);

    // 5: resync pulse flushes buffered beats
    do_reset();
    stream_ready = 1'b0;
    for (int i = 1; i <= 3; i++) pix(DW'(i), i == 1);
    chk("t5_valid_before", {31'd0, stream_valid}, 32'd1);
    video_stream_reset = 1'b0;
    tick();
    video_stream_reset = 1'b1;
    chk("t5_flushed", {31'd0, stream_valid}, 32'd0);
    chk("t5_no_pop", got_q.size(), 32'd0);
    stream_ready = 1'b1;
    send_frame(24'h10);
    exp_frame(24'h10);
    drain();
    check_beats("t5");
    chk("t5_fc", {16'd0, frame_count}, 32'd1);

    // 6: back-to-back frames with ready toggling every cycle
    do_reset();
    stream_ready = 1'b0;
    for (int f = 1; f <= 2; f++) begin
      for (int i = 1; i <= 8; i++) begin
        t6_step(1'b1, DW'(f * 256 + i), i == 1);
        t6_step(1'b0, '0, 1'b0);
      end
    end
    stream_ready = 1'b1;
    exp_frame(24'h100);
    exp_frame(24'h200);
    drain();
    check_beats("t6");
    chk("t6_fc", {16'd0, frame_count}, 32'd2);
    chk("t6_ovf", {31'd0, overflow_err}, 32'd0);
    chk("t6_ferr", {31'd0, frame_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
